uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one 8N1 UART tx engine between N byte requesters.
// Define ARB_TIMEOUT_EN to build the tx_done watchdog and its sticky timeout_err flag.
module uart_tx_arbiter #(
    parameter int N           = 4,
    parameter int GAP_CYC     = 5208,
    parameter int TIMEOUT_CYC = 57288,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [8*N-1:0]  req_data,
    output logic [N-1:0]    req_ack,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_done,
    output logic            busy,
    output logic [IW-1:0]   grant_id,
    output logic            timeout_err
);

    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [GW-1:0]   gap_q;
    logic [N-1:0]    req_ack_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic            busy_q;
    logic [IW-1:0]   grant_id_q;

    logic [IW-1:0]   win_d;
    logic            found_d;
    int              idx;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0]   wd_q;
    logic            timeout_q;
`endif

    // Walk from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        win_d   = ptr_q;
        found_d = |req;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) begin
                win_d = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(N - 1);
            gap_q      <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
`ifdef ARB_TIMEOUT_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        tx_data_q  <= req_data[{win_d, 3'b000} +: 8];
                        grant_id_q <= win_d;
                        ptr_q      <= win_d;
                        req_ack_q  <= {{(N-1){1'b0}}, 1'b1} << win_d;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_start_q <= 1'b1;
                    state_q    <= WAIT;
`ifdef ARB_TIMEOUT_EN
                    wd_q       <= '0;
`endif
                end
                WAIT: begin
`ifdef ARB_TIMEOUT_EN
                    wd_q <= wd_q + TW'(1);
`endif
                    if (tx_done) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
`ifdef ARB_TIMEOUT_EN
                    // A dead engine is treated as a finished frame.
                    else if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= GAP;
                    end
`endif
                end
                GAP: begin
                    if ((GAP_CYC == 0) || (gap_q == GW'(GAP_LAST))) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a random run
// compared against a cycle-arithmetic model of the round-robin schedule.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 6;
    localparam int TMO = 100;
    localparam int HSZ = 32768;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done_w;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    logic eng_done = 1'b0;
    logic spur_done = 1'b0;
    logic rnd_done = 1'b0;
    logic eng_en = 1'b0;
    logic rnd_en = 1'b0;
    int   eng_min = 4;
    int   eng_max = 4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mh;

    assign tx_done_w = eng_done | spur_done | rnd_done;

    uart_tx_arbiter #(
        .N(N),
        .GAP_CYC(GAP),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_ack(req_ack),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_done(tx_done_w),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]     bq [N][$];
    logic [N-1:0]   req_h  [HSZ];
    logic [8*N-1:0] dat_h  [HSZ];
    logic           done_h [HSZ];
    logic           busy_h [HSZ];
    logic           to_h   [HSZ];

    int           ack_cyc[$];
    logic [N-1:0] ack_vec[$];
    int           st_cyc[$];
    logic [7:0]   st_dat[$];
    logic [1:0]   st_gid[$];
    int           done_cyc[$];

    int         m_ptr;
    int         m_free;
    int         e_ack[$];
    int         e_id[$];
    int         e_st[$];
    logic [7:0] e_dat[$];

    // Requesters: hold req with the queue head until acked, then present the next byte.
    always @(posedge clk) begin
        #2;
        rnd_done = rnd_en && ($urandom_range(0, 39) == 0);
        for (int i = 0; i < N; i++) begin
            if (req[i] && req_ack[i] && bq[i].size() != 0) void'(bq[i].pop_front());
            req[i] = bq[i].size() != 0;
            req_data[8*i +: 8] = (bq[i].size() != 0) ? bq[i][0] : 8'h00;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && eng_en) begin
                int d;
                d = $urandom_range(eng_min, eng_max);
                repeat (d) @(posedge clk);
                #1 eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        mh = cyc % HSZ;
        req_h[mh]  = req;
        dat_h[mh]  = req_data;
        done_h[mh] = tx_done_w;
        busy_h[mh] = busy;
        to_h[mh]   = timeout_err;
        if (req_ack != '0) begin
            ack_cyc.push_back(cyc);
            ack_vec.push_back(req_ack);
        end
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(tx_data);
            st_gid.push_back(grant_id);
        end
        if (tx_done_w) done_cyc.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ack_cyc.delete(); ack_vec.delete();
        st_cyc.delete(); st_dat.delete(); st_gid.delete();
        done_cyc.delete();
        e_ack.delete(); e_id.delete(); e_st.delete(); e_dat.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        clear_logs();
        m_ptr  = N - 1;
        m_free = cyc;
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Replays recorded inputs: a request seen in an idle cycle k is acked at k+1,
    // started at k+2; the first tx_done from k+2 on ends the frame, then the gap.
    task automatic model_run(input int upto);
        int k, w, d;
        forever begin
            k = m_free;
            while (k < upto && req_h[k % HSZ] == '0) k++;
            if (k >= upto) begin
                m_free = upto;
                return;
            end
            w = rr_pick(req_h[k % HSZ], m_ptr);
            e_ack.push_back(k + 1);
            e_id.push_back(w);
            e_st.push_back(k + 2);
            e_dat.push_back(dat_h[k % HSZ][8*w +: 8]);
            m_ptr = w;
            d = k + 2;
            while (d < upto && !done_h[d % HSZ]) d++;
            if (d >= upto) begin
                m_free = upto;
                return;
            end
            m_free = d + ((GAP == 0) ? 1 : GAP) + 1;
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (req_ack !== '0) begin failures++; $display("FAIL rst_ack got=%b exp=0", req_ack); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_gid got=%0d exp=0", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rst_to got=%b exp=0", timeout_err); end
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_single();
        int t0, n, c;
        bit allhi;
        do_reset();
        eng_en = 1'b1; eng_min = 5; eng_max = 5;
        t0 = cyc;
        bq[0].push_back(8'h55);
        n = 0;
        while (done_cyc.size() < 1 && n < 60) begin step(1); n++; end
        checks++;
        if (done_cyc.size() < 1 || st_cyc.size() < 1) begin
            failures++; $display("FAIL single_wait got=%0d frames exp=1", st_cyc.size());
            return;
        end
        c = done_cyc[0];
        step(GAP + 4);
        checks++; if (ack_cyc[0] !== t0 + 1) begin failures++; $display("FAIL single_ack_lat got=%0d exp=%0d", ack_cyc[0], t0 + 1); end
        checks++; if (ack_vec[0] !== 4'b0001) begin failures++; $display("FAIL single_ack_vec got=%b exp=0001", ack_vec[0]); end
        checks++; if (st_cyc[0] !== t0 + 2) begin failures++; $display("FAIL single_start_lat got=%0d exp=%0d", st_cyc[0], t0 + 2); end
        checks++; if (st_dat[0] !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", st_dat[0]); end
        checks++; if (st_gid[0] !== 2'd0) begin failures++; $display("FAIL single_gid got=%0d exp=0", st_gid[0]); end
        checks++; if (ack_cyc.size() !== 1) begin failures++; $display("FAIL single_ack_count got=%0d exp=1", ack_cyc.size()); end
        allhi = 1'b1;
        for (int k = t0 + 1; k <= c + GAP; k++) allhi &= busy_h[k % HSZ];
        checks++; if (allhi !== 1'b1) begin failures++; $display("FAIL single_busy_hold got=%b exp=1", allhi); end
        checks++; if (busy_h[(c + GAP + 1) % HSZ] !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy_h[(c + GAP + 1) % HSZ]); end
    endtask

    task automatic test_rr();
        int n;
        do_reset();
        eng_en = 1'b1; eng_min = 3; eng_max = 15;
        for (int i = 0; i < N; i++) bq[i].push_back(8'h10 + 8'(i));
        n = 0;
        while (done_cyc.size() < 4 && n < 400) begin step(1); n++; end
        step(GAP + 4);
        checks++;
        if (st_cyc.size() != 4 || done_cyc.size() != 4) begin
            failures++; $display("FAIL rr_count got=%0d starts exp=4", st_cyc.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (st_gid[i] !== 2'(i)) begin failures++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", i, st_gid[i], i); end
            checks++; if (st_dat[i] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, st_dat[i], 8'h10 + 8'(i)); end
            if (i > 0) begin
                checks++;
                if (st_cyc[i] - done_cyc[i-1] !== GAP + 3) begin
                    failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", i, st_cyc[i] - done_cyc[i-1], GAP + 3);
                end
            end
        end
    endtask

    task automatic test_fair();
        logic [7:0] b0 [4];
        logic [7:0] b2 [4];
        int n;
        clear_logs();
        eng_en = 1'b1; eng_min = 2; eng_max = 10;
        for (int k = 0; k < 4; k++) begin
            b0[k] = 8'($urandom_range(0, 255));
            b2[k] = 8'($urandom_range(0, 255));
            bq[0].push_back(b0[k]);
            bq[2].push_back(b2[k]);
        end
        n = 0;
        while (done_cyc.size() < 8 && n < 800) begin step(1); n++; end
        step(GAP + 4);
        checks++;
        if (st_cyc.size() != 8) begin
            failures++; $display("FAIL fair_count got=%0d exp=8", st_cyc.size());
            return;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (st_gid[i] !== ((i % 2 == 0) ? 2'd0 : 2'd2)) begin
                failures++; $display("FAIL fair_gid[%0d] got=%0d exp=%0d", i, st_gid[i], (i % 2 == 0) ? 0 : 2);
            end
            checks++;
            if (st_dat[i] !== ((i % 2 == 0) ? b0[i/2] : b2[i/2])) begin
                failures++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, st_dat[i], (i % 2 == 0) ? b0[i/2] : b2[i/2]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b1;
        int n, t0;
        clear_logs();
        eng_en = 1'b0;
        bq[3].push_back(8'h80 | 8'($urandom_range(0, 127)));
        n = 0;
        while (st_cyc.size() < 1 && n < 20) begin step(1); n++; end
        step(5);
        rst = 1'b1;
        #1;
        checks++; if (req_ack !== '0) begin failures++; $display("FAIL mid_rst_ack got=%b exp=0", req_ack); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_rst_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", tx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_rst_gid got=%0d exp=0", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL mid_rst_to got=%b exp=0", timeout_err); end
        step(2);
        rst = 1'b0;
        clear_logs();
        eng_en = 1'b1; eng_min = 4; eng_max = 4;
        b1 = 8'($urandom_range(1, 255));
        t0 = cyc;
        bq[1].push_back(b1);
        step(30);
        checks++;
        if (st_cyc.size() != 1 || ack_cyc.size() != 1) begin
            failures++; $display("FAIL mid_count got=%0d starts exp=1", st_cyc.size());
            return;
        end
        checks++; if (ack_vec[0] !== 4'b0010) begin failures++; $display("FAIL mid_ack_vec got=%b exp=0010", ack_vec[0]); end
        checks++; if (st_dat[0] !== b1) begin failures++; $display("FAIL mid_data got=%h exp=%h", st_dat[0], b1); end
        checks++; if (st_gid[0] !== 2'd1) begin failures++; $display("FAIL mid_gid got=%0d exp=1", st_gid[0]); end
        checks++; if (st_cyc[0] !== t0 + 2) begin failures++; $display("FAIL mid_start_lat got=%0d exp=%0d", st_cyc[0], t0 + 2); end
    endtask

    task automatic test_spurious();
        int t0, c;
        clear_logs();
        eng_en = 1'b0;
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(4);
        checks++; if (ack_cyc.size() !== 0) begin failures++; $display("FAIL spur_idle_ack got=%0d exp=0", ack_cyc.size()); end
        checks++; if (st_cyc.size() !== 0) begin failures++; $display("FAIL spur_idle_start got=%0d exp=0", st_cyc.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle_busy got=%b exp=0", busy); end
        t0 = cyc;
        bq[2].push_back(8'h3C);
        step(1);
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(10);
        checks++;
        if (st_cyc.size() != 1) begin
            failures++; $display("FAIL spur_start_count got=%0d exp=1", st_cyc.size());
            return;
        end
        checks++; if (st_cyc[0] !== t0 + 2) begin failures++; $display("FAIL spur_start_lat got=%0d exp=%0d", st_cyc[0], t0 + 2); end
        checks++; if (st_dat[0] !== 8'h3C) begin failures++; $display("FAIL spur_data got=%h exp=3c", st_dat[0]); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spur_start_busy got=%b exp=1", busy); end
        c = cyc;
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(GAP + 3);
        checks++; if (busy_h[(c + GAP) % HSZ] !== 1'b1) begin failures++; $display("FAIL spur_gap_busy got=%b exp=1", busy_h[(c + GAP) % HSZ]); end
        checks++; if (busy_h[(c + GAP + 1) % HSZ] !== 1'b0) begin failures++; $display("FAIL spur_gap_idle got=%b exp=0", busy_h[(c + GAP + 1) % HSZ]); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        eng_en = 1'b0;
        bq[0].push_back(8'hA0);
        bq[1].push_back(8'hA1);
        n = 0;
        while (st_cyc.size() < 1 && n < 20) begin step(1); n++; end
        checks++;
        if (st_cyc.size() < 1) begin
            failures++; $display("FAIL to_first_start got=0 exp=1");
        end else begin
`ifdef ARB_TIMEOUT_EN
            int s;
            s = st_cyc[0];
            n = 0;
            while (st_cyc.size() < 2 && n < 300) begin step(1); n++; end
            step(5);
            checks++; if (to_h[(s + 99) % HSZ] !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", to_h[(s + 99) % HSZ]); end
            checks++; if (to_h[(s + 100) % HSZ] !== 1'b1) begin failures++; $display("FAIL to_rise got=%b exp=1", to_h[(s + 100) % HSZ]); end
            checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
            checks++;
            if (st_cyc.size() < 2) begin
                failures++; $display("FAIL to_next_grant got=%0d starts exp=2", st_cyc.size());
            end else begin
                checks++; if (st_gid[1] !== 2'd1) begin failures++; $display("FAIL to_next_gid got=%0d exp=1", st_gid[1]); end
                checks++; if (st_cyc[1] !== s + GAP + 102) begin failures++; $display("FAIL to_next_lat got=%0d exp=%0d", st_cyc[1], s + GAP + 102); end
                checks++; if (st_dat[1] !== 8'hA1) begin failures++; $display("FAIL to_next_data got=%h exp=a1", st_dat[1]); end
            end
`else
            step(300);
            checks++; if (st_cyc.size() !== 1) begin failures++; $display("FAIL to_stuck_starts got=%0d exp=1", st_cyc.size()); end
            checks++; if (ack_cyc.size() !== 1) begin failures++; $display("FAIL to_stuck_acks got=%0d exp=1", ack_cyc.size()); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_stuck_busy got=%b exp=1", busy); end
            checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_flag got=%b exp=0", timeout_err); end
`endif
        end
        for (int i = 0; i < N; i++) bq[i].delete();
        step(1);
        do_reset();
    endtask

    task automatic test_random();
        int n, m;
        logic [N-1:0] r;
        logic [N-1:0] one;
        do_reset();
        eng_en = 1'b1; eng_min = 1; eng_max = 25;
        rnd_en = 1'b1;
        repeat (60) begin
            step($urandom_range(1, 25));
            r = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (r[i]) bq[i].push_back(8'($urandom_range(0, 255)));
            end
        end
        n = 0;
        while ((bq[0].size() + bq[1].size() + bq[2].size() + bq[3].size()) != 0 && n < 4000) begin
            step(1); n++;
        end
        checks++;
        if (n >= 4000) begin failures++; $display("FAIL rand_drain got=%0d cycles exp=<4000", n); end
        rnd_en = 1'b0;
        step(80);
        model_run(cyc);
        checks++; if (st_cyc.size() !== e_st.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", st_cyc.size(), e_st.size()); end
        checks++; if (ack_cyc.size() !== e_ack.size()) begin failures++; $display("FAIL rand_acks got=%0d exp=%0d", ack_cyc.size(), e_ack.size()); end
        m = (st_cyc.size() < e_st.size()) ? st_cyc.size() : e_st.size();
        if (ack_cyc.size() < m) m = ack_cyc.size();
        for (int i = 0; i < m; i++) begin
            one = N'(1) << e_id[i];
            checks++; if (ack_cyc[i] !== e_ack[i]) begin failures++; $display("FAIL rand_ack_cyc[%0d] got=%0d exp=%0d", i, ack_cyc[i], e_ack[i]); end
            checks++; if (ack_vec[i] !== one) begin failures++; $display("FAIL rand_ack_vec[%0d] got=%b exp=%b", i, ack_vec[i], one); end
            checks++; if (st_cyc[i] !== e_st[i]) begin failures++; $display("FAIL rand_st_cyc[%0d] got=%0d exp=%0d", i, st_cyc[i], e_st[i]); end
            checks++; if (st_dat[i] !== e_dat[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, st_dat[i], e_dat[i]); end
            checks++; if (st_gid[i] !== 2'(e_id[i])) begin failures++; $display("FAIL rand_gid[%0d] got=%0d exp=%0d", i, st_gid[i], e_id[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_fair();
        test_reset_mid();
        test_spurious();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
